// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MOD up/down counter whose state bits are JK flops.
// The excitation logic works out the wanted next count, then turns it into
// per-bit J/K pairs. Each flop sets, clears, or holds its own bit from its
// J/K pair. The count is never written straight into the flops.

// One JK storage bit with async active-low clear.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic equation: set on J, clear on K, toggle on both, hold on neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= (j & ~q) | (~k & q);
  end

endmodule

module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             ld_err
);

  // Largest legal count. When MOD == 2**WIDTH this is all ones, so the range
  // checks below are always true and the out-of-range path cannot fire.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             in_range;
  logic             d_ok;
  logic             at_max;
  logic             at_zero;

  assign in_range = (q <= MAXV);
  assign d_ok     = (d <= MAXV);
  assign at_max   = (q == MAXV);
  assign at_zero  = (q == '0);

  // Zero-latency terminal count. When q is out of range it never matches either end.
  assign tc = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  // Target count, in priority order: load, then count, then hold.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = d_ok ? d : '0;
    end else if (en) begin
      if (!in_range)   nxt = '0;
      else if (up_dn)  nxt = at_max  ? '0   : q + WIDTH'(1);
      else             nxt = at_zero ? MAXV : q - WIDTH'(1);
    end
  end

  // Excitation: set bits that must rise, clear bits that must fall, else J=K=0.
  always_comb begin
    j = nxt & ~q;
    k = ~nxt & q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_bit (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  // Wrap pulse is the sampled tc; load error flags a too-large load value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      co     <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      co     <= tc;
      ld_err <= load & ~d_ok;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter. Two instances share the same stimulus: MOD=10
// (partial range) and MOD=16 (full range). The bench runs directed scenarios
// with literal expectations, then a long randomized run. An arithmetic model
// of each counter is compared against the DUT on every falling edge.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = '0;

  logic [3:0] q10, q16;
  logic       tc10, tc16, co10, co16, le10, le16;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MOD(10)) u10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q10), .tc(tc10), .co(co10), .ld_err(le10)
  );

  jk_mod_counter #(.WIDTH(4), .MOD(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q16), .tc(tc16), .co(co16), .ld_err(le16)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next-state model from plain arithmetic; returns {ld_err, co, q[5:0]}.
  function automatic logic [7:0] step(input int mod, input int q, input bit e,
                                      input bit up, input bit ld, input int dv);
    if (ld) return (dv < mod) ? {2'b00, 6'(dv)} : {2'b10, 6'd0};
    if (!e) return {2'b00, 6'(q)};
    if (q >= mod) return 8'd0;
    if (up) return (q == mod - 1) ? {2'b01, 6'd0} : {2'b00, 6'(q + 1)};
    return (q == 0) ? {2'b01, 6'(mod - 1)} : {2'b00, 6'(q - 1)};
  endfunction

  function automatic bit tc_of(input int mod, input int q);
    return en && !load && ((up_dn && q == mod - 1) || (!up_dn && q == 0));
  endfunction

  logic [7:0] m10, m16;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m10 <= 8'd0;
      m16 <= 8'd0;
    end else begin
      m10 <= step(10, int'(m10[5:0]), en, up_dn, load, int'(d));
      m16 <= step(16, int'(m16[5:0]), en, up_dn, load, int'(d));
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_q10",  int'(q10),  int'(m10[5:0]));
      chk("m_co10", int'(co10), int'(m10[6]));
      chk("m_le10", int'(le10), int'(m10[7]));
      chk("m_tc10", int'(tc10), int'(tc_of(10, int'(m10[5:0]))));
      chk("m_q16",  int'(q16),  int'(m16[5:0]));
      chk("m_co16", int'(co16), int'(m16[6]));
      chk("m_le16", int'(le16), int'(m16[7]));
      chk("m_tc16", int'(tc16), int'(tc_of(16, int'(m16[5:0]))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with enable active: inputs ignored, tc reflects q=0 counting down.
    en = 1'b1; up_dn = 1'b0;
    #2 rst = 1'b0;
    cmp_on = 1'b1;
    #1;
    chk("rst_q", int'(q10), 0);
    chk("rst_tc", int'(tc10), 1);
    repeat (2) tick();
    chk("rst_hold_q", int'(q10), 0);
    chk("rst_hold_co", int'(co10), 0);
    chk("rst_hold_le", int'(le10), 0);
    en = 1'b0;
    rst = 1'b1;

    // Up wrap over MOD=10.
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      #1 chk("up_tc", int'(tc10), int'(i - 1 == 9));
      tick();
      chk("up_q", int'(q10), i % 10);
      chk("up_co", int'(co10), int'(i == 10));
    end

    // Down wrap from 0.
    up_dn = 1'b0;
    #1 chk("dn_tc0", int'(tc10), 1);
    tick();
    chk("dn_q9", int'(q10), 9);
    chk("dn_co9", int'(co10), 1);
    tick();
    chk("dn_q8", int'(q10), 8);
    chk("dn_co8", int'(co10), 0);

    // Load priority, then illegal load.
    load = 1'b1; d = 4'd6; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("ld6_q", int'(q10), 6);
    chk("ld6_co", int'(co10), 0);
    chk("ld6_le", int'(le10), 0);
    d = 4'd12;
    tick();
    chk("ld12_q", int'(q10), 0);
    chk("ld12_le", int'(le10), 1);
    chk("ld12_q16", int'(q16), 12);
    load = 1'b0; en = 1'b0;
    tick();
    chk("ld12_le_drop", int'(le10), 0);

    // Hold, then direction toggling every edge.
    load = 1'b1; d = 4'd4;
    tick();
    load = 1'b0; en = 1'b0;
    repeat (3) tick();
    chk("hold_q", int'(q10), 4);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      chk("dir_q", int'(q10), (i % 2 == 0) ? 5 : 4);
    end

    // Reset asserted between edges while q=7.
    load = 1'b1; d = 4'd7;
    tick();
    chk("pre_rst_q", int'(q10), 7);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async_q", int'(q10), 0);
    chk("async_co", int'(co10), 0);
    chk("async_le", int'(le10), 0);
    repeat (2) tick();
    chk("rst_ign_q", int'(q10), 0);
    rst = 1'b1;
    en = 1'b0;

    // Full-range instance (MOD=16).
    load = 1'b1; d = 4'd15;
    tick();
    chk("f_ld15_q", int'(q16), 15);
    chk("f_ld15_le", int'(le16), 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1 chk("f_tc15", int'(tc16), 1);
    tick();
    chk("f_up_q", int'(q16), 0);
    chk("f_up_co", int'(co16), 1);
    up_dn = 1'b0;
    tick();
    chk("f_dn_q", int'(q16), 15);
    chk("f_dn_co", int'(co16), 1);

    // Randomized run with occasional mid-cycle reset pulses.
    for (int n = 0; n < 2000; n++) begin
      tick();
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1) != 0;
      d     = 4'($urandom_range(0, 15));
      if (rst && $urandom_range(0, 149) == 0) #2 rst = 1'b0;
      else if (!rst && $urandom_range(0, 2) == 0) #2 rst = 1'b1;
    end
    rst = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
